// File: rtl/port_array_merge_if.sv
// Port-array-in / single-stream-out bundle for the round-robin merge stage.
// The producer side (master) drives the port array and out_rdy; the merge block (slave) drives the rest.
interface port_array_merge_if #(
    parameter int nports = 2,
    parameter int nbits  = 32
);
    localparam int SW = $clog2(nports);

    logic [nports-1:0]            in_val;
    logic [nports-1:0]            in_rdy;
    logic [nports-1:0][nbits-1:0] in_;
    logic                         out_val;
    logic                         out_rdy;
    logic [nbits-1:0]             out;
    logic [SW-1:0]                out_src;

    modport master (
        output in_val, in_, out_rdy,
        input  in_rdy, out_val, out, out_src
    );

    modport slave (
        input  in_val, in_, out_rdy,
        output in_rdy, out_val, out, out_src
    );
endinterface

// File: rtl/port_array_merge.sv
// Round-robin merge of a val/rdy port array into one registered, source-tagged stream; 1-cycle latency.
// Backpressure: a full register with out_rdy low drops every in_rdy and freezes all state.
module port_array_merge #(
    parameter int nports = 2,
    parameter int nbits  = 32
) (
    input  logic              clk,
    input  logic              reset,
    port_array_merge_if.slave bus
);
    localparam int SW = $clog2(nports);

    logic             full;
    logic [nbits-1:0] data_q;
    logic [SW-1:0]    src_q;
    logic [SW-1:0]    ptr;

    logic             can_accept;
    logic             found;
    logic             take;
    logic [SW-1:0]    winner;
    logic [SW:0]      scan;
    logic [nports-1:0] rdy;

    assign can_accept = !full || bus.out_rdy;

    // Scan ptr, ptr+1, ... with an explicit modulo wrap so non-power-of-two nports stays in range.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        scan   = '0;
        for (int k = 0; k < nports; k++) begin
            scan = {1'b0, ptr} + (SW+1)'(k);
            if (scan >= (SW+1)'(nports)) begin
                scan = scan - (SW+1)'(nports);
            end
            if (!found && bus.in_val[scan[SW-1:0]]) begin
                found  = 1'b1;
                winner = scan[SW-1:0];
            end
        end
    end

    assign take = !reset && can_accept && found;

    always_comb begin
        rdy = '0;
        for (int i = 0; i < nports; i++) begin
            if (take && (winner == SW'(i))) begin
                rdy[i] = 1'b1;
            end
        end
    end

    assign bus.in_rdy = rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            ptr    <= '0;
        end else if (take) begin
            // A simultaneous drain and load simply overwrites, keeping one word per cycle.
            full   <= 1'b1;
            data_q <= bus.in_[winner];
            src_q  <= winner;
            ptr    <= (winner == SW'(nports - 1)) ? '0 : winner + 1'b1;
        end else if (full && bus.out_rdy) begin
            full   <= 1'b0;
        end
    end

    assign bus.out_val = full;
    assign bus.out     = data_q;
    assign bus.out_src = src_q;
endmodule

// File: tb/tb_port_array_merge.sv
// Scoreboard bench: scenario tasks push expected words, per-DUT monitors pop them on output transfers.
module tb_port_array_merge;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    port_array_merge_if #(.nports(2), .nbits(32)) a ();
    port_array_merge_if #(.nports(4), .nbits(32)) b ();

    port_array_merge #(.nports(2), .nbits(32)) dut2 (.clk(clk), .reset(reset), .bus(a));
    port_array_merge #(.nports(4), .nbits(32)) dut4 (.clk(clk), .reset(reset), .bus(b));

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  src;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (a.out_val === 1'b1 && a.out_rdy === 1'b1) begin
            exp_t e;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL merge2_out: unexpected word %h src %0d", a.out, a.out_src);
            end else begin
                e = qa.pop_front();
                if (a.out !== e.dat || {1'b0, a.out_src} !== e.src) begin
                    errors++;
                    $display("FAIL merge2_out: got %h/src %0d, want %h/src %0d", a.out, a.out_src, e.dat, e.src);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b.out_val === 1'b1 && b.out_rdy === 1'b1) begin
            exp_t e;
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL merge4_out: unexpected word %h src %0d", b.out, b.out_src);
            end else begin
                e = qb.pop_front();
                if (b.out !== e.dat || b.out_src !== e.src) begin
                    errors++;
                    $display("FAIL merge4_out: got %h/src %0d, want %h/src %0d", b.out, b.out_src, e.dat, e.src);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        a.in_val = '0;
        b.in_val = '0;
        next();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        a.in_val  = 2'b11;
        a.in_[0]  = 32'hA;
        a.in_[1]  = 32'hB;
        a.out_rdy = 1'b1;
        b.in_val  = 4'b1111;
        b.in_     = '0;
        b.out_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (a.in_rdy !== 2'b00 || a.out_val !== 1'b0 || a.out !== 32'h0 || a.out_src !== 1'b0) begin
                errors++;
                $display("FAIL reset_state2: rdy %b val %b out %h src %0d, want 00 0 0 0", a.in_rdy, a.out_val, a.out, a.out_src);
            end
            checks++;
            if (b.in_rdy !== 4'b0000 || b.out_val !== 1'b0 || b.out !== 32'h0 || b.out_src !== 2'd0) begin
                errors++;
                $display("FAIL reset_state4: rdy %b val %b out %h src %0d, want 0000 0 0 0", b.in_rdy, b.out_val, b.out, b.out_src);
            end
            next();
        end
        reset    = 1'b0;
        b.in_val = '0;
        @(negedge clk);
        checks++;
        if (a.in_rdy !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: in_rdy %b, want 01", a.in_rdy);
        end
        qa.push_back({32'hA, 2'd0});
        next();
        a.in_val = '0;
        @(negedge clk);
        checks++;
        if (a.out_val !== 1'b1) begin
            errors++;
            $display("FAIL reset_latency: out_val %b, want 1", a.out_val);
        end
        next();
    endtask

    task automatic test_alternation();
        do_reset();
        a.in_val  = 2'b11;
        a.in_[0]  = 32'hA;
        a.in_[1]  = 32'hB;
        a.out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (a.in_rdy !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL alternation_rdy[%0d]: in_rdy %b, want %b", c, a.in_rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (c > 0) begin
                checks++;
                if (a.out_val !== 1'b1) begin
                    errors++;
                    $display("FAIL alternation_val[%0d]: out_val %b, want 1", c, a.out_val);
                end
            end
            qa.push_back((c % 2 == 0) ? {32'hA, 2'd0} : {32'hB, 2'd1});
            next();
        end
        a.in_val = '0;
        @(negedge clk);
        next();
    endtask

    task automatic test_backpressure();
        do_reset();
        a.in_val  = 2'b01;
        a.in_[0]  = 32'hA;
        a.in_[1]  = 32'hB;
        a.out_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (a.in_rdy !== 2'b01) begin
            errors++;
            $display("FAIL bp_load: in_rdy %b, want 01", a.in_rdy);
        end
        qa.push_back({32'hA, 2'd0});
        next();
        a.in_val = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (a.in_rdy !== 2'b00 || a.out_val !== 1'b1 || a.out !== 32'hA || a.out_src !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rdy %b val %b out %h src %0d, want 00 1 a 0", c, a.in_rdy, a.out_val, a.out, a.out_src);
            end
            next();
        end
        a.out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (a.in_rdy !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: in_rdy %b, want 10", a.in_rdy);
        end
        qa.push_back({32'hB, 2'd1});
        next();
        a.in_val = '0;
        @(negedge clk);
        checks++;
        if (a.out_val !== 1'b1 || a.out !== 32'hB) begin
            errors++;
            $display("FAIL bp_no_bubble: val %b out %h, want 1 b", a.out_val, a.out);
        end
        next();
    endtask

    task automatic test_single_requester();
        do_reset();
        a.in_val  = 2'b10;
        a.out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            a.in_[1] = 32'h100 + 32'(c);
            @(negedge clk);
            checks++;
            if (a.in_rdy !== 2'b10) begin
                errors++;
                $display("FAIL single_rdy[%0d]: in_rdy %b, want 10", c, a.in_rdy);
            end
            if (c > 0) begin
                checks++;
                if (a.out_val !== 1'b1) begin
                    errors++;
                    $display("FAIL single_val[%0d]: out_val %b, want 1", c, a.out_val);
                end
            end
            qa.push_back({32'h100 + 32'(c), 2'd1});
            next();
        end
        a.in_val = '0;
        @(negedge clk);
        next();
    endtask

    task automatic test_pointer_hold();
        do_reset();
        a.in_val  = 2'b01;
        a.in_[0]  = 32'hC;
        a.in_[1]  = 32'hB;
        a.out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (a.in_rdy !== 2'b01) begin
            errors++;
            $display("FAIL hold_first: in_rdy %b, want 01", a.in_rdy);
        end
        qa.push_back({32'hC, 2'd0});
        next();
        a.in_val = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (a.in_rdy !== 2'b00) begin
                errors++;
                $display("FAIL hold_idle[%0d]: in_rdy %b, want 00", c, a.in_rdy);
            end
            next();
        end
        a.in_val = 2'b11;
        @(negedge clk);
        checks++;
        if (a.in_rdy !== 2'b10) begin
            errors++;
            $display("FAIL hold_priority: in_rdy %b, want 10", a.in_rdy);
        end
        qa.push_back({32'hB, 2'd1});
        next();
        a.in_val = '0;
        @(negedge clk);
        next();
    endtask

    task automatic test_reset_flush();
        do_reset();
        a.in_val  = 2'b01;
        a.in_[0]  = 32'hE;
        a.in_[1]  = 32'hF;
        a.out_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (a.in_rdy !== 2'b01) begin
            errors++;
            $display("FAIL flush_load: in_rdy %b, want 01", a.in_rdy);
        end
        next();
        reset    = 1'b1;
        a.in_val = 2'b11;
        next();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (a.out_val !== 1'b0 || a.in_rdy !== 2'b01) begin
            errors++;
            $display("FAIL flush_after_reset: val %b rdy %b, want 0 01", a.out_val, a.in_rdy);
        end
        qa.push_back({32'hE, 2'd0});
        next();
        a.in_val  = '0;
        a.out_rdy = 1'b1;
        @(negedge clk);
        next();
    endtask

    task automatic test_wrap_sparse();
        logic [3:0] exp_rdy [3] = '{4'b0001, 4'b0100, 4'b0001};
        logic [1:0] exp_src [3] = '{2'd0, 2'd2, 2'd0};
        do_reset();
        b.out_rdy = 1'b1;
        b.in_val  = 4'b1000;
        b.in_[3]  = 32'hD3;
        @(negedge clk);
        checks++;
        if (b.in_rdy !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_setup: in_rdy %b, want 1000", b.in_rdy);
        end
        qb.push_back({32'hD3, 2'd3});
        next();
        b.in_val = 4'b0101;
        b.in_[0] = 32'h10;
        b.in_[2] = 32'h12;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (b.in_rdy !== exp_rdy[c]) begin
                errors++;
                $display("FAIL wrap_rdy[%0d]: in_rdy %b, want %b", c, b.in_rdy, exp_rdy[c]);
            end
            qb.push_back({(exp_src[c] == 2'd0) ? 32'h10 : 32'h12, exp_src[c]});
            next();
        end
        b.in_val = '0;
        @(negedge clk);
        next();
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_backpressure();
        test_single_requester();
        test_pointer_hold();
        test_reset_flush();
        test_wrap_sparse();
        next();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d words still expected, want 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
